// File: rtl/rx_mac_if.sv
// rx_mac_if: RGMII receive byte stream into the MAC and the AXI-Stream frame bytes out of it.
interface rx_mac_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data;
  logic                  rgmii_mac_rx_dv;
  logic                  rgmii_mac_rx_er;
  logic [DATA_WIDTH-1:0] m_rx_axis_tdata;
  logic                  m_rx_axis_tvalid;
  logic                  m_rx_axis_tlast;
  logic                  m_rx_axis_tuser;
  logic                  s_rx_axis_trdy;
  modport master (
    input  rgmii_mac_rx_data, rgmii_mac_rx_dv, rgmii_mac_rx_er, s_rx_axis_trdy,
    output m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser
  );
  modport slave (
    output rgmii_mac_rx_data, rgmii_mac_rx_dv, rgmii_mac_rx_er, s_rx_axis_trdy,
    input  m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser
  );
endinterface

// File: rtl/rx_mac_core.sv
// rx_mac_core: Ethernet RX MAC that strips preamble/SFD/FCS and flags CRC, PHY-error, runt and overflow frames.
module rx_mac_core #(parameter int DATA_WIDTH = 8) (
  input logic      clk,
  input logic      reset_n,
  rx_mac_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PRE = 2'd1, S_PAY = 2'd2, S_DROP = 2'd3;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [1:0]                 r_state;
  logic [31:0]                r_crc;
  logic [15:0]                r_cnt;
  logic [4:0][DATA_WIDTH-1:0] r_buf;
  logic                       r_err, r_ovf;
  logic [DATA_WIDTH-1:0]      r_tdata;
  logic                       r_tvalid, r_tlast, r_tuser;
  logic [DATA_WIDTH-1:0]      w_data;
  logic                       w_dv, w_er, w_full, w_ovf_now, w_bad;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction
  assign w_data    = bus.rgmii_mac_rx_data;
  assign w_dv      = bus.rgmii_mac_rx_dv;
  assign w_er      = bus.rgmii_mac_rx_er;
  assign w_full    = r_cnt >= 16'd5;
  // the beat on the bus right now may itself be refused while the frame is closing
  assign w_ovf_now = r_ovf | (r_tvalid & ~bus.s_rx_axis_trdy);
  assign w_bad     = (r_crc != CRC_RESIDUE) | r_err | (r_cnt < 16'd64) | w_ovf_now;
  assign bus.m_rx_axis_tdata  = r_tdata;
  assign bus.m_rx_axis_tvalid = r_tvalid;
  assign bus.m_rx_axis_tlast  = r_tlast;
  assign bus.m_rx_axis_tuser  = r_tuser;
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state  <= S_IDLE;
      r_crc    <= 32'hFFFFFFFF;
      r_cnt    <= 16'd0;
      r_buf    <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      if (r_tvalid && !bus.s_rx_axis_trdy) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (w_dv) r_state <= (w_data == 8'h55) ? S_PRE : S_DROP;
        S_PRE: begin
          if (!w_dv) r_state <= S_IDLE;
          else if (w_data == 8'hD5) begin
            r_state <= S_PAY;
            r_crc   <= 32'hFFFFFFFF;
            r_cnt   <= 16'd0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
          end else if (w_data != 8'h55) r_state <= S_DROP;
        end
        S_PAY: begin
          if (w_dv) begin
            r_crc <= crc_byte(r_crc, w_data);
            r_buf <= {r_buf[3:0], w_data};
            r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            if (w_er) r_err <= 1'b1;
            if (w_full) begin
              r_tdata  <= r_buf[4];
              r_tvalid <= 1'b1;
            end
          end else begin
            // the four youngest buffered bytes are the FCS and are dropped here
            r_state <= S_IDLE;
            if (w_full) begin
              r_tdata  <= r_buf[4];
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b1;
              r_tuser  <= w_bad;
            end
          end
        end
        default: if (!w_dv) r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_mac_core.sv
// tb_rx_mac_core: random and directed Ethernet frames checked against a frame-level model of the receive MAC.
module tb_rx_mac_core;
  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] d; logic l; logic u; } beat_t;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_d = 8'h00;
  always #5 clk = ~clk;
  rx_mac_if #(.DATA_WIDTH(8)) bus();
  rx_mac_core #(.DATA_WIDTH(8)) dut (.clk(clk), .reset_n(rst), .bus(bus));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic logic [31:0] crc_of(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction
  function automatic bq_t with_fcs(input bq_t p);
    bq_t q;
    logic [31:0] f;
    q = p;
    f = ~crc_of(p);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    return q;
  endfunction
  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rdy);
    @(posedge clk);
    #1;
    bus.rgmii_mac_rx_dv   = dv;
    bus.rgmii_mac_rx_data = d;
    bus.rgmii_mac_rx_er   = er;
    bus.s_rx_axis_trdy    = rdy;
  endtask
  // Model: every byte after the SFD except the last four is forwarded; the frame verdict rides on tlast.
  task automatic send(input bq_t body, input int npre, input logic [7:0] sfd, input int er_idx,
                      input int rdy_idx, input int abort_idx, input int gap);
    int n;
    logic bad;
    n = body.size();
    if (sfd == 8'hD5) begin
      int nb;
      nb = (abort_idx >= 0) ? (abort_idx > 6 ? abort_idx - 6 : 0) : (n >= 5 ? n - 4 : 0);
      bad = (crc_of(body) != RESIDUE) || (er_idx >= 0 && er_idx < n) || n < 64 || (rdy_idx >= 6 && rdy_idx < n);
      for (int j = 0; j < nb; j++)
        exp_q.push_back('{body[j], abort_idx < 0 && j == nb - 1, abort_idx < 0 && j == nb - 1 && bad});
    end
    repeat (npre) drive(1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, sfd, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_idx) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rgmii_mac_rx_dv = 1'b0;
        #1;
        chk("rst_tvalid", {31'd0, bus.m_rx_axis_tvalid}, 0);
        chk("rst_tlast", {31'd0, bus.m_rx_axis_tlast}, 0);
        chk("rst_tuser", {31'd0, bus.m_rx_axis_tuser}, 0);
        chk("rst_tdata", {24'd0, bus.m_rx_axis_tdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      drive(1'b1, body[i], i == er_idx, i != rdy_idx);
    end
    repeat (gap) drive(1'b0, 8'h00, 1'b0, 1'b1);
    if (gap >= 2) begin
      @(negedge clk);
      #1;
      chk("frame_drained", exp_q.size(), 0);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst) last_d = 8'h00;
      else if (bus.m_rx_axis_tvalid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {24'd0, bus.m_rx_axis_tdata}, 32'hFFFFFFFF);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("tdata", {24'd0, bus.m_rx_axis_tdata}, {24'd0, b.d});
          chk("tlast", {31'd0, bus.m_rx_axis_tlast}, {31'd0, b.l});
          chk("tuser", {31'd0, bus.m_rx_axis_tuser}, {31'd0, b.u});
        end
        last_d = bus.m_rx_axis_tdata;
      end else begin
        chk("idle_flags", {30'd0, bus.m_rx_axis_tlast, bus.m_rx_axis_tuser}, 0);
        chk("tdata_hold", {24'd0, bus.m_rx_axis_tdata}, {24'd0, last_d});
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bq_t p, f, ck;
    bus.rgmii_mac_rx_dv = 1'b0;
    bus.rgmii_mac_rx_data = 8'h00;
    bus.rgmii_mac_rx_er = 1'b0;
    bus.s_rx_axis_trdy = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", {31'd0, bus.m_rx_axis_tvalid}, 0);
    chk("reset_tdata", {24'd0, bus.m_rx_axis_tdata}, 0);
    rst = 1'b0;
    ck = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", ~crc_of(ck), 32'hCBF43926);
    for (int i = 0; i < 60; i++) p.push_back(i[7:0]);
    f = with_fcs(p);
    chk("model_residue", crc_of(f), RESIDUE);
    chk("model_len", f.size(), 64);
    send(f, 7, 8'hD5, -1, -1, -1, 3);
    f[63] ^= 8'h01;
    send(f, 7, 8'hD5, -1, -1, -1, 3);
    f = with_fcs(p);
    send(f, 7, 8'hD5, 30, -1, -1, 3);
    p.delete();
    for (int i = 0; i < 40; i++) p.push_back(8'hA0 ^ i[7:0]);
    send(with_fcs(p), 3, 8'hD5, -1, -1, -1, 3);
    send('{8'h11, 8'h22, 8'h33}, 2, 8'hD5, -1, -1, -1, 3);
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(i[7:0]);
    f = with_fcs(p);
    send(f, 7, 8'hD4, -1, -1, -1, 1);
    send(f, 7, 8'hD5, -1, -1, -1, 3);
    send(f, 7, 8'hD5, -1, 20, -1, 3);
    send(f, 7, 8'hD5, -1, -1, 30, 0);
    send(f, 7, 8'hD5, -1, -1, -1, 3);
    for (int k = 0; k < 30; k++) begin
      int len, er_i, rdy_i, gap;
      logic [7:0] sfd;
      p.delete();
      len = $urandom_range(1, 90);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      f = ($urandom_range(0, 7) == 0) ? p[0:($urandom_range(0, 4) < len ? $urandom_range(0, 4) : len) - 1] : with_fcs(p);
      if ($urandom_range(0, 5) == 0 && f.size() > 0) f[$urandom_range(0, f.size() - 1)] ^= 8'h10;
      er_i  = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 95) : -1;
      rdy_i = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 95) : -1;
      sfd   = ($urandom_range(0, 7) == 0) ? 8'hD7 : 8'hD5;
      gap   = $urandom_range(1, 3);
      send(f, $urandom_range(1, 8), sfd, er_i, rdy_i, -1, gap);
    end
    repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rx_mac_core.md
Name: rx_mac_core

Overview:
Ethernet receive MAC, sitting between the RGMII receive interface (byte-wide, one byte per clock) and the receive FIFO.
- Strips preamble, SFD and FCS.
- Checks CRC-32, RX error and minimum length.
- Forwards frame bytes as an AXI-Stream master, flagging bad frames with tuser on the tlast beat.

Parameters:
DATA_WIDTH, 8, byte width of RGMII data and AXI-Stream data; only 8 is supported.

Ports:
clk  in  1  single clock for all logic (RGMII RX clock domain)
reset_n  in  1  asynchronous reset, active-high despite the name
rgmii_mac_rx_data  in  DATA_WIDTH  received byte
rgmii_mac_rx_dv  in  1  data valid; high for the whole frame, including preamble
rgmii_mac_rx_er  in  1  PHY receive error
m_rx_axis_tdata  out  DATA_WIDTH  frame byte (destination MAC through last payload byte)
m_rx_axis_tvalid  out  1  byte valid, one-cycle strobe per byte
m_rx_axis_tlast  out  1  last byte of frame, coincident with its tvalid
m_rx_axis_tuser  out  1  bad-frame flag, meaningful only when tlast=1
s_rx_axis_trdy  in  1  downstream ready

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register = 0xFFFFFFFF, byte buffer empty, error flags cleared. Reset mid-frame abandons the frame; no tlast is emitted.
- All outputs are registered. tvalid, tlast and tuser are 0 except on output cycles; tdata holds its last value.
- IDLE: on dv=1 with data=0x55 -> PREAMBLE. dv=1 with any other byte -> DROP.
- PREAMBLE: data=0x55 stays. data=0xD5 (SFD) -> PAYLOAD, with CRC and counters initialised. Any other byte -> DROP. dv=0 -> IDLE. There is no check on preamble count; one or more 0x55 bytes are accepted.
- DROP: ignore input until dv=0, then -> IDLE. Nothing is output.
- PAYLOAD, on each byte with dv=1:
  - Update reflected CRC-32 (polynomial 0xEDB88320, LSB first) with the byte; FCS bytes are included.
  - Shift the byte into a 5-byte delay buffer.
  - If the buffer already held 5 bytes, emit the oldest: tvalid=1, tlast=0, next cycle.
  - Count bytes (16-bit, saturating).
  - er=1 on any dv=1 cycle sets the error flag.
- PAYLOAD, on dv=0 (end of frame):
  - If at least 5 bytes were received, emit the oldest buffered byte with tvalid=1 and tlast=1. The 4 remaining buffered bytes are the FCS and are discarded.
  - tuser=1 if any of: CRC register != 0xDEBB20E3 (residue); error flag set; total bytes after SFD < 64; overflow flag set.
  - If fewer than 5 bytes were received, discard silently with no output.
  - State -> IDLE.
- Latency: a byte is emitted 5 bytes after it enters. The final data byte is emitted the cycle after dv falls (registered).
- Backpressure: the PHY cannot be stalled. If s_rx_axis_trdy=0 on any output cycle, the byte is still presented (not repeated) and the overflow flag is set, so that frame ends with tuser=1.
- dv may reassert the cycle after a frame ends; the new frame is handled normally from IDLE.

Test Plan:
- Frame of 7x0x55, 0xD5, 60 bytes (0x00..0x3B), correct FCS, trdy=1 -> 60 beats with data 0x00..0x3B, tlast on byte 0x3B, tuser=0; no FCS bytes on output.
- Same frame with last FCS byte XOR 0x01 -> 60 beats, tlast with tuser=1.
- Good frame with er=1 for one cycle mid-payload -> all 60 beats, tuser=1 on tlast.
- 40-byte payload with valid FCS (44 bytes after SFD) -> 40 beats, tlast with tuser=1 (runt); a 3-byte burst after SFD -> no output at all.
- Bad SFD (preamble then 0xD4 then data) -> no tvalid; the next good frame sent back-to-back (dv low 1 cycle) -> received correctly with tuser=0.
- trdy=0 for one beat mid-frame -> tuser=1 on tlast. Separately, reset asserted mid-payload -> outputs 0 immediately, no tlast, and the next frame is received correctly.
